// File: rtl/serial_det_pkg.sv
// Shared types and elaboration helpers for the serial detector scheduler.
package serial_det_pkg;

   typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_e;

   // Counter width able to index 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit params_ok(input int nreq, input int w, input int det_lat,
                                    input int idw, input int cw);
      return (nreq >= 1) && (w >= 1) && (det_lat >= 0) &&
             ((2 ** idw) >= nreq) && ((2 ** cw) > w);
   endfunction

endpackage

// File: rtl/serial_det_sched_if.sv
// Requester and detector signal bundle for serial_det_sched.
interface serial_det_sched_if #(
   parameter int NREQ = 2,
   parameter int W    = 8,
   parameter int IDW  = 1,
   parameter int CW   = 4
);
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] data;
   logic [NREQ-1:0]   gnt;
   logic              det_rst;
   logic              det_x;
   logic              det_y;
   logic              done;
   logic [IDW-1:0]    done_id;
   logic [CW-1:0]     match_cnt;

   modport slave (input req, data, det_y,
                  output gnt, det_rst, det_x, done, done_id, match_cnt);
   modport master (output req, data, det_y,
                   input gnt, det_rst, det_x, done, done_id, match_cnt);
endinterface

// File: rtl/serial_det_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded id, pointer advances past each winner.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NREQ-1:0] req,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  id,
   output logic            any
);
   logic [IDW-1:0] ptr_q, ptr_d;

   always_comb begin
      gnt   = '0;
      id    = '0;
      any   = 1'b0;
      ptr_d = ptr_q;
      // Scan farthest-first so the requester nearest the pointer wins last.
      for (int off = NREQ - 1; off >= 0; off--) begin
         if (req[(int'(ptr_q) + off) % NREQ]) begin
            id  = IDW'((int'(ptr_q) + off) % NREQ);
            any = 1'b1;
         end
      end
      if (en && any) begin
         gnt[id] = 1'b1;
         ptr_d   = (int'(id) == NREQ - 1) ? '0 : IDW'(int'(id) + 1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end
endmodule

// File: rtl/serial_det_sched.sv
// Shares one serial sequence detector among NREQ requesters: grant, clear,
// shift a word MSB-first, count matches, report the count with the requester id.
module serial_det_sched
   import serial_det_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int W       = 8,
   parameter int DET_LAT = 1,
   parameter int IDW     = 1,
   parameter int CW      = 4
) (
   input logic              clk,
   input logic              reset,
   serial_det_sched_if.slave bus
);
   localparam int BCW = cnt_w((W > DET_LAT) ? W : DET_LAT);

   if (!params_ok(NREQ, W, DET_LAT, IDW, CW)) begin : g_bad_params
      $error("serial_det_sched: illegal parameter combination");
   end

   state_e         state_q, state_d;
   logic [W-1:0]   sr_q, sr_d;
   logic [IDW-1:0] id_q, id_d;
   logic [BCW-1:0] bcnt_q, bcnt_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           det_rst_q, det_rst_d, det_x_q, det_x_d, done_q, done_d;
   logic [IDW-1:0] done_id_q, done_id_d;
   logic [CW-1:0]  match_cnt_q, match_cnt_d;

   logic            arb_en, arb_any, shift_vld, vld_dly;
   logic [NREQ-1:0] arb_gnt;
   logic [IDW-1:0]  arb_id;

   assign arb_en = (state_q == IDLE) && !reset;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (bus.req),
      .en    (arb_en),
      .gnt   (arb_gnt),
      .id    (arb_id),
      .any   (arb_any)
   );

   // Valid delay line aligns each shifted bit with the det_y it produces.
   assign shift_vld = (state_q == SHIFT);
   if (DET_LAT > 0) begin : g_dly
      logic [DET_LAT-1:0] vld_pipe;
      always_ff @(posedge clk or posedge reset) begin
         if (reset) vld_pipe <= '0;
         else begin
            for (int i = DET_LAT - 1; i > 0; i--) vld_pipe[i] <= vld_pipe[i-1];
            vld_pipe[0] <= shift_vld;
         end
      end
      assign vld_dly = vld_pipe[DET_LAT-1];
   end else begin : g_nodly
      assign vld_dly = shift_vld;
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      id_d    = id_q;
      bcnt_d  = bcnt_q;
      cnt_d   = cnt_q;
      if (vld_dly && bus.det_y) cnt_d = cnt_q + 1'b1;
      case (state_q)
         IDLE: if (arb_en && arb_any) begin
            sr_d    = bus.data[arb_id*W +: W];
            id_d    = arb_id;
            cnt_d   = '0;
            state_d = CLR;
         end
         CLR: begin
            bcnt_d  = '0;
            state_d = SHIFT;
         end
         SHIFT: if (bcnt_q == BCW'(W - 1)) begin
            bcnt_d  = '0;
            state_d = (DET_LAT == 0) ? DONE : DRAIN;
         end else bcnt_d = bcnt_q + 1'b1;
         DRAIN: if (bcnt_q == BCW'(DET_LAT - 1)) state_d = DONE;
                else bcnt_d = bcnt_q + 1'b1;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are registered, so they are decoded from the next state.
      det_rst_d = (state_d == CLR);
      det_x_d   = (state_d == SHIFT) && sr_q[W-1];
      if (state_d == SHIFT) sr_d = sr_q << 1;
      done_d      = (state_d == DONE);
      done_id_d   = done_d ? id_q  : done_id_q;
      match_cnt_d = done_d ? cnt_d : match_cnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         id_q        <= '0;
         bcnt_q      <= '0;
         cnt_q       <= '0;
         det_rst_q   <= 1'b0;
         det_x_q     <= 1'b0;
         done_q      <= 1'b0;
         done_id_q   <= '0;
         match_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         id_q        <= id_d;
         bcnt_q      <= bcnt_d;
         cnt_q       <= cnt_d;
         det_rst_q   <= det_rst_d;
         det_x_q     <= det_x_d;
         done_q      <= done_d;
         done_id_q   <= done_id_d;
         match_cnt_q <= match_cnt_d;
      end
   end

   assign bus.gnt       = arb_gnt;
   assign bus.det_rst   = det_rst_q;
   assign bus.det_x     = det_x_q;
   assign bus.done      = done_q;
   assign bus.done_id   = done_id_q;
   assign bus.match_cnt = match_cnt_q;
endmodule

// File: tb/tb_serial_det_sched.sv
// Directed bench for serial_det_sched driving an overlapping "101" Moore detector model.
module tb_serial_det_sched;
   localparam int NREQ = 2, W = 8, DET_LAT = 1, IDW = 1, CW = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   serial_det_sched_if #(.NREQ(NREQ), .W(W), .IDW(IDW), .CW(CW)) bus ();
   serial_det_sched #(.NREQ(NREQ), .W(W), .DET_LAT(DET_LAT), .IDW(IDW), .CW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Detector: 0 idle, 1 saw "1", 2 saw "10", 3 saw "101" (y high)
   logic [1:0] dst = 2'd0;
   always @(posedge clk) begin
      if (bus.det_rst) dst <= 2'd0;
      else case (dst)
         2'd0:    dst <= bus.det_x ? 2'd1 : 2'd0;
         2'd1:    dst <= bus.det_x ? 2'd1 : 2'd2;
         2'd2:    dst <= bus.det_x ? 2'd3 : 2'd0;
         default: dst <= bus.det_x ? 2'd1 : 2'd2;
      endcase
   end
   assign bus.det_y = (dst == 2'd3);

   int n_cmp = 0, n_bad = 0, cyc = 0, n_done = 0;
   always @(posedge clk) begin
      #2;
      cyc++;
      if (bus.done === 1'b1) n_done++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_gnt(output bit ok);
      ok = 1'b0;
      #1;
      for (int i = 0; i < 40; i++) begin
         if (bus.gnt != '0) begin
            ok = 1'b1;
            return;
         end
         step();
      end
      chk("gnt_timeout", 0, 1);
   endtask

   // One full job: grant, clear, W shifted bits, drain, done, plus one hold cycle.
   task automatic do_job(input logic [1:0] rq, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [1:0] drop, input int exp_id, input int exp_cnt,
                         input int pulse_at, output int g);
      bit ok;
      logic [7:0] word;
      g = 0;
      bus.req  = rq;
      bus.data = {d1, d0};
      wait_gnt(ok);
      if (!ok) return;
      g = cyc;
      chk("gnt_onehot", bus.gnt, 32'd1 << exp_id);
      word = (exp_id == 1) ? d1 : d0;
      @(posedge clk);
      #1;
      bus.req = bus.req & ~drop;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (k <= 11) chk("gnt_busy", bus.gnt, 0);
         if (k == 1) begin
            chk("det_rst_clr", bus.det_rst, 1);
            chk("done_early", bus.done, 0);
         end else if (k <= 9) begin
            chk("det_x_bit", bus.det_x, word[9-k]);
            chk("det_rst_shift", bus.det_rst, 0);
         end else if (k == 10) begin
            chk("det_x_drain", bus.det_x, 0);
            chk("done_drain", bus.done, 0);
         end else if (k == 11) begin
            chk("done_pulse", bus.done, 1);
            chk("done_latency", cyc - g, 11);
            chk("done_id", bus.done_id, exp_id);
            chk("match_cnt", bus.match_cnt, exp_cnt);
         end else begin
            chk("done_clear", bus.done, 0);
            chk("match_cnt_hold", bus.match_cnt, exp_cnt);
         end
         if (pulse_at > 0 && k == pulse_at)     bus.req[1] = 1'b1;
         if (pulse_at > 0 && k == pulse_at + 1) bus.req[1] = 1'b0;
      end
   endtask

   typedef struct {
      logic [1:0] rq;
      logic [7:0] d0;
      logic [7:0] d1;
      int         id;
      int         cnt;
   } vec_t;

   vec_t tbl[9];

   initial begin
      bit ok;
      int g, prev_g;
      tbl[0] = '{2'b01, 8'b01010111, 8'h00, 0, 2};
      tbl[1] = '{2'b10, 8'h00, 8'b10101101, 1, 3};
      tbl[2] = '{2'b01, 8'h00, 8'h00, 0, 0};
      tbl[3] = '{2'b10, 8'h00, 8'hFF, 1, 0};
      tbl[4] = '{2'b01, 8'b10100000, 8'h00, 0, 1};
      tbl[5] = '{2'b01, 8'b00000001, 8'h00, 0, 0};
      // "10" left over from this word would make the next word's leading 1 match
      tbl[6] = '{2'b01, 8'b00000010, 8'h00, 0, 0};
      tbl[7] = '{2'b01, 8'b10000000, 8'h00, 0, 0};
      tbl[8] = '{2'b10, 8'h00, 8'b01011010, 1, 2};

      bus.req  = 2'b01;
      bus.data = '0;
      step();
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_det_rst", bus.det_rst, 0);
      chk("rst_det_x", bus.det_x, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_done_id", bus.done_id, 0);
      chk("rst_match_cnt", bus.match_cnt, 0);
      bus.req = 2'b00;
      step();
      reset = 1'b0;
      step();

      foreach (tbl[i])
         do_job(tbl[i].rq, tbl[i].d0, tbl[i].d1, tbl[i].rq, tbl[i].id, tbl[i].cnt, 0, g);

      // All requesting: grants alternate, one job every W+DET_LAT+3 cycles
      prev_g = 0;
      for (int j = 0; j < 4; j++) begin
         do_job(2'b11, 8'b01010111, 8'b10101101, (j == 3) ? 2'b11 : 2'b00,
                j % 2, (j % 2 == 1) ? 3 : 2, 0, g);
         if (j > 0) chk("rr_spacing", g - prev_g, 12);
         prev_g = g;
      end

      // Requester 1 pulses for one cycle mid-job and must never be served
      do_job(2'b01, 8'b01010111, 8'h00, 2'b01, 0, 2, 3, g);
      for (int k = 0; k < 6; k++) begin
         chk("idle_gnt", bus.gnt, 0);
         chk("idle_done", bus.done, 0);
         step();
      end

      // Reset mid-SHIFT with pointer favouring requester 1
      bus.req  = 2'b01;
      bus.data = {8'h00, 8'b01010111};
      wait_gnt(ok);
      @(posedge clk);
      #1;
      bus.req = 2'b00;
      for (int k = 0; k < 4; k++) step();
      bus.req = 2'b11;
      reset   = 1'b1;
      #1;
      chk("mid_rst_det_x", bus.det_x, 0);
      chk("mid_rst_det_rst", bus.det_rst, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_gnt", bus.gnt, 0);
      chk("mid_rst_done_id", bus.done_id, 0);
      chk("mid_rst_match_cnt", bus.match_cnt, 0);
      step();
      step();
      chk("mid_rst_gnt_hold", bus.gnt, 0);
      reset = 1'b0;
      do_job(2'b11, 8'b01010111, 8'b10101101, 2'b11, 0, 2, 0, g);
      step();

      chk("total_done_pulses", n_done, 15);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
